// File: rtl/div_nonrestore_pkg.sv
// Shared definitions for the non-restoring divider family.
// Holds the controller state encoding and the default iteration count.
package div_nonrestore_pkg;

  // Default operand width; one quotient bit is produced per iteration.
  localparam int ITER_CNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    CORR = 2'd2
  } state_t;

endpackage

// File: rtl/div_addsub_step.sv
// One radix-2 non-restoring iteration: shift the partial remainder left,
// then subtract or add the divisor depending on the current sign.
module div_addsub_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   r,
  input  logic              q_msb,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W:0]   r_next,
  output logic              q_bit
);

  logic [DATA_W:0] rs_s;
  logic [DATA_W:0] d_ext_s;

  // Add or subtract the divisor; the sign of the new remainder is the quotient bit.
  always_comb begin
    rs_s    = {r[DATA_W-1:0], q_msb};
    d_ext_s = {1'b0, d};
    if (r[DATA_W]) begin
      r_next = rs_s + d_ext_s;
    end else begin
      r_next = rs_s - d_ext_s;
    end
    q_bit = ~r_next[DATA_W];
  end

endmodule

// File: rtl/div_nonrestore.sv
// Iterative radix-2 non-restoring unsigned divider with a fixed-latency
// start/done handshake (DATA_W+1 edges from start to done, divide-by-zero included).
module div_nonrestore
  import div_nonrestore_pkg::*;
#(
  parameter int DATA_W = ITER_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  state_t            state_r, state_s;
  logic [DATA_W:0]   r_r, r_s, r_step_s, r_fix_s;
  logic [DATA_W-1:0] q_r, q_s;
  logic [DATA_W-1:0] d_r, d_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              dbz_r, dbz_s;
  logic              q_bit_s;
  logic              busy_s, done_s, div_by_zero_s;
  logic [DATA_W-1:0] quotient_s, remainder_s;

  div_addsub_step #(.DATA_W(DATA_W)) u_step (
    .r      (r_r),
    .q_msb  (q_r[DATA_W-1]),
    .d      (d_r),
    .r_next (r_step_s),
    .q_bit  (q_bit_s)
  );

  // Next-state and datapath update; a start pulse overrides whatever is in progress.
  always_comb begin
    state_s       = state_r;
    r_s           = r_r;
    q_s           = q_r;
    d_s           = d_r;
    cnt_s         = cnt_r;
    dbz_s         = dbz_r;
    busy_s        = busy;
    done_s        = 1'b0;
    quotient_s    = quotient;
    remainder_s   = remainder;
    div_by_zero_s = div_by_zero;
    r_fix_s       = r_r;
    if (start) begin
      r_s     = '0;
      q_s     = dividend;
      d_s     = divisor;
      dbz_s   = (divisor == '0);
      cnt_s   = '0;
      state_s = ITER;
      busy_s  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          busy_s = 1'b0;
        end
        ITER: begin
          r_s   = r_step_s;
          q_s   = {q_r[DATA_W-2:0], q_bit_s};
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_s = CORR;
          end else begin
            state_s = ITER;
          end
        end
        CORR: begin
          // A negative final remainder still holds one extra divisor subtraction.
          if (r_r[DATA_W]) begin
            r_fix_s = r_r + {1'b0, d_r};
          end else begin
            r_fix_s = r_r;
          end
          r_s           = r_fix_s;
          quotient_s    = q_r;
          remainder_s   = r_fix_s[DATA_W-1:0];
          div_by_zero_s = dbz_r;
          done_s        = 1'b1;
          busy_s        = 1'b0;
          state_s       = IDLE;
        end
        default: begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      r_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt_r       <= '0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_r     <= state_s;
      r_r         <= r_s;
      q_r         <= q_s;
      d_r         <= d_s;
      cnt_r       <= cnt_s;
      dbz_r       <= dbz_s;
      busy        <= busy_s;
      done        <= done_s;
      quotient    <= quotient_s;
      remainder   <= remainder_s;
      div_by_zero <= div_by_zero_s;
    end
  end

endmodule
